// File: rtl/pop_arbiter_pkg.sv
// Shared definitions for the pop arbiter: port count, data and counter widths,
// and the controller state encoding.
package pop_arbiter_pkg;

  localparam int NUM_PORTS = 4;
  localparam int PTR_W     = 2;   // log2(NUM_PORTS)
  localparam int DATA_W    = 12;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Four-request round-robin arbiter with an internal pointer.
// Grants the first asserted request at or after the pointer; the pointer then
// moves to the slot after the granted one, and stays put when nothing is granted.
//
// Ports:
//   clk       clock, rising edge
//   reset     synchronous active-high reset, pointer -> 0
//   en        allow a grant this cycle
//   clear     force pointer to 0 at the next edge (overrides advance)
//   req       request vector, one bit per port
//   gnt       one-hot grant
//   gnt_valid a grant was issued this cycle
//   gnt_idx   index of the granted port
module rr_arbiter
  import pop_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 clear,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] gnt,
  output logic                 gnt_valid,
  output logic [PTR_W-1:0]     gnt_idx
);

  logic [PTR_W-1:0] rr_q;
  logic [PTR_W-1:0] cand;

  // Scan from the pointer upward; the PTR_W-bit add wraps 3 -> 0 for free.
  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    gnt       = '0;
    cand      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = rr_q + PTR_W'(i);
      if (en && !gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
    if (gnt_valid) gnt[gnt_idx] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rr_q <= '0;
    end else if (gnt_valid) begin
      rr_q <= gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/pop_arbiter.sv
// Merges four output FIFOs into one word stream.
// One pop per cycle (round robin, skipping empty FIFOs) while ACTIVE and not
// paused; the popped FIFO's head word is captured into data_out and presented
// with valid_out on the following cycle. Per-port 5-bit word counters can be
// read back one cycle after a request.
//
// Ports:
//   clk                   clock, rising edge
//   reset                 synchronous active-high reset
//   init                  pulse: clear counters and pointer, enter ACTIVE
//   emptyP0..3            FIFO empty flags
//   dataOutputP0..3       FIFO head words
//   pause                 downstream almost-full, blocks new pops
//   req, idx              counter read request and port index
//   popOutP0..3           pop strobes
//   data_out, valid_out   merged word and its valid flag
//   counterOut            counter value read for idx
//   counterValid          counterOut valid
module pop_arbiter
  import pop_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              emptyP0,
  input  logic              emptyP1,
  input  logic              emptyP2,
  input  logic              emptyP3,
  input  logic [DATA_W-1:0] dataOutputP0,
  input  logic [DATA_W-1:0] dataOutputP1,
  input  logic [DATA_W-1:0] dataOutputP2,
  input  logic [DATA_W-1:0] dataOutputP3,
  input  logic              pause,
  input  logic              req,
  input  logic [PTR_W-1:0]  idx,
  output logic              popOutP0,
  output logic              popOutP1,
  output logic              popOutP2,
  output logic              popOutP3,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [CNT_W-1:0]  counterOut,
  output logic              counterValid
);

  state_t state_q, state_d;

  logic [NUM_PORTS-1:0] empty_vec;
  logic [DATA_W-1:0]    fifo_data [NUM_PORTS];
  logic [NUM_PORTS-1:0] pop_vec;
  logic                 gnt_valid;
  logic [PTR_W-1:0]     gnt_idx;
  logic                 arb_en;
  logic                 clear_cnt;

  logic [PTR_W-1:0]     valid_port_q;
  logic [CNT_W-1:0]     cnt_q [NUM_PORTS];

  assign empty_vec    = {emptyP3, emptyP2, emptyP1, emptyP0};
  assign fifo_data[0] = dataOutputP0;
  assign fifo_data[1] = dataOutputP1;
  assign fifo_data[2] = dataOutputP2;
  assign fifo_data[3] = dataOutputP3;

  // Pops are also masked during reset so a FIFO is never drained of a word
  // whose result the reset would discard anyway.
  assign arb_en    = (state_q == ST_ACTIVE) && !pause && !reset;
  assign clear_cnt = init && ((state_q == ST_IDLE) || (state_q == ST_ACTIVE));

  rr_arbiter u_rr_arbiter (
    .clk       (clk),
    .reset     (reset),
    .en        (arb_en),
    .clear     (clear_cnt),
    .req       (~empty_vec),
    .gnt       (pop_vec),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign popOutP0 = pop_vec[0];
  assign popOutP1 = pop_vec[1];
  assign popOutP2 = pop_vec[2];
  assign popOutP3 = pop_vec[3];

  // Controller: RESET -> INIT -> IDLE -> (init) ACTIVE; only reset leaves ACTIVE.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RESET;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   state_d = ST_IDLE;
      ST_IDLE:   if (init) state_d = ST_ACTIVE;
      ST_ACTIVE: state_d = ST_ACTIVE;
      default:   state_d = ST_RESET;
    endcase
  end

  // Output word register: data_out holds its last value when nothing was popped.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out    <= 1'b0;
      data_out     <= '0;
      valid_port_q <= '0;
    end else begin
      valid_out <= gnt_valid;
      if (gnt_valid) begin
        data_out     <= fifo_data[gnt_idx];
        valid_port_q <= gnt_idx;
      end
    end
  end

  // Counters bump at the end of the valid_out cycle, so a read in that same
  // cycle sees the pre-increment value. A clear wins over a pending increment.
  // NOTE: the counter array is a handful of flops read back by software, so it
  // is reset explicitly rather than treated as uninitialised storage.
  always_ff @(posedge clk) begin
    if (reset || clear_cnt) begin
      for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= '0;
    end else if (valid_out) begin
      cnt_q[valid_port_q] <= cnt_q[valid_port_q] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counterValid <= 1'b0;
      counterOut   <= '0;
    end else begin
      counterValid <= req;
      if (req) counterOut <= cnt_q[idx];
    end
  end

endmodule

// File: tb/tb_pop_arbiter.sv
// Bench for pop_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_pop_arbiter;

  logic        clk = 1'b0;
  logic        reset, init, pause, req;
  logic [1:0]  idx;
  logic [3:0]  empty;
  logic [11:0] din [4];
  logic        pop0, pop1, pop2, pop3;
  logic [3:0]  pop;
  logic [11:0] data_out;
  logic        valid_out;
  logic [4:0]  counter_out;
  logic        counter_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign pop = {pop3, pop2, pop1, pop0};

  pop_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .emptyP0      (empty[0]),
    .emptyP1      (empty[1]),
    .emptyP2      (empty[2]),
    .emptyP3      (empty[3]),
    .dataOutputP0 (din[0]),
    .dataOutputP1 (din[1]),
    .dataOutputP2 (din[2]),
    .dataOutputP3 (din[3]),
    .pause        (pause),
    .req          (req),
    .idx          (idx),
    .popOutP0     (pop0),
    .popOutP1     (pop1),
    .popOutP2     (pop2),
    .popOutP3     (pop3),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .counterOut   (counter_out),
    .counterValid (counter_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. Phase: 0 reset, 1 init, 2 idle, 3 active.
  // e_* are the register outputs expected in the next cycle.
  // ---------------------------------------------------------------------------
  int          m_phase = 0;
  int          m_rr    = 0;
  int          m_cnt [4];
  bit          e_valid = 0;
  logic [11:0] e_data  = '0;
  int          e_port  = 0;
  bit          e_cv    = 0;
  logic [4:0]  e_co    = '0;
  bit          synced  = 0;

  always @(negedge clk) begin
    int         g;
    logic [3:0] e_pop;
    bit         clr;
    g = -1;
    if (m_phase == 3 && !pause) begin
      for (int i = 0; i < 4; i++)
        if (g < 0 && !empty[(m_rr + i) % 4]) g = (m_rr + i) % 4;
    end
    e_pop = 4'b0;
    if (g >= 0) e_pop[g] = 1'b1;

    if (synced) begin
      if (!reset) check("pop", pop, e_pop);
      check("valid_out", valid_out, e_valid);
      check("data_out", data_out, e_data);
      check("counterValid", counter_valid, e_cv);
      check("counterOut", counter_out, e_co);
    end

    if (reset) begin
      m_phase = 0;
      m_rr    = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      e_valid = 0;
      e_data  = '0;
      e_cv    = 0;
      e_co    = '0;
      synced  = 1;
    end else begin
      clr  = init && (m_phase >= 2);
      e_cv = req;
      if (req) e_co = 5'(m_cnt[idx]);
      if (e_valid) m_cnt[e_port] = (m_cnt[e_port] + 1) % 32;
      e_valid = (g >= 0);
      if (g >= 0) begin
        e_data = din[g];
        e_port = g;
        m_rr   = (g + 1) % 4;
      end
      if (clr) begin
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_rr = 0;
      end
      case (m_phase)
        0: m_phase = 1;
        1: m_phase = 2;
        2: m_phase = init ? 3 : 2;
        default: m_phase = 3;
      endcase
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus with hand-computed expectations
  // ---------------------------------------------------------------------------
  initial begin
    logic [11:0] rr_vals [4];
    rr_vals[0] = 12'd15; rr_vals[1] = 12'd20; rr_vals[2] = 12'd25; rr_vals[3] = 12'd30;

    reset = 1'b1; init = 1'b0; pause = 1'b0; req = 1'b0; idx = 2'd0;
    empty = 4'hF;
    for (int i = 0; i < 4; i++) din[i] = '0;

    // Reset for two cycles, then release.
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst pop", pop, 4'b0);
    check("rst valid_out", valid_out, 1'b0);
    check("rst data_out", data_out, 12'd0);
    check("rst counterValid", counter_valid, 1'b0);
    check("rst counterOut", counter_out, 5'd0);
    tick();            // RESET -> INIT
    tick();            // INIT -> IDLE
    init = 1'b1;
    tick();            // IDLE -> ACTIVE
    init = 1'b0;
    @(negedge clk);
    check("active idle pop", pop, 4'b0);
    check("active idle valid", valid_out, 1'b0);

    // Round robin over four non-empty FIFOs.
    tick();
    empty = 4'h0;
    for (int i = 0; i < 4; i++) din[i] = rr_vals[i];
    for (int k = 0; k < 6; k++) begin
      logic [3:0] exp_pop;
      exp_pop = 4'b0;
      if (k < 5) exp_pop[k % 4] = 1'b1;
      @(negedge clk);
      check("rr pop", pop, exp_pop);
      if (k > 0) begin
        check("rr valid_out", valid_out, 1'b1);
        check("rr data_out", data_out, rr_vals[(k - 1) % 4]);
      end
      tick();
      if (k == 4) empty = 4'hF;
    end

    // Only P2 non-empty.
    empty = 4'b1011;
    din[2] = 12'd35;
    @(negedge clk);
    check("skip pop", pop, 4'b0100);
    tick();
    empty = 4'hF;
    @(negedge clk);
    check("skip valid_out", valid_out, 1'b1);
    check("skip data_out", data_out, 12'd35);
    check("skip pop after", pop, 4'b0);

    // Pop P3 (pointer at 3), then pause for three cycles.
    tick();
    empty = 4'h0;
    @(negedge clk);
    check("pre-pause pop", pop, 4'b1000);
    tick();
    pause = 1'b1;
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      check("pause pop", pop, 4'b0);
      check("pause valid_out", valid_out, (p == 0) ? 1'b1 : 1'b0);
      if (p == 0) check("pause data_out", data_out, 12'd30);
      tick();
    end
    pause = 1'b0;
    empty = 4'hF;
    tick();

    // Clear counters, push 33 words from P1, read its counter.
    init = 1'b1;
    tick();
    init = 1'b0;
    empty = 4'b1101;
    repeat (33) tick();
    empty = 4'hF;
    tick();
    req = 1'b1; idx = 2'd1;
    tick();
    req = 1'b0;
    @(negedge clk);
    check("cnt wrap valid", counter_valid, 1'b1);
    check("cnt wrap value", counter_out, 5'd1);

    // Reset in the middle of a pop stream.
    tick();
    empty = 4'h0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    empty = 4'hF;
    @(negedge clk);
    check("midrst valid_out", valid_out, 1'b0);
    check("midrst pop", pop, 4'b0);
    check("midrst data_out", data_out, 12'd0);
    tick(); tick();
    init = 1'b1;
    tick();
    init = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req = 1'b1; idx = 2'(i);
      tick();
      req = 1'b0;
      @(negedge clk);
      check("midrst cnt valid", counter_valid, 1'b1);
      check("midrst cnt value", counter_out, 5'd0);
    end

    // Randomized traffic; the model checks every cycle.
    tick();
    repeat (4000) begin
      reset = ($urandom_range(0, 299) == 0);
      init  = ($urandom_range(0, 39) == 0);
      pause = ($urandom_range(0, 3) == 0);
      empty = ($urandom_range(0, 1) == 0) ? 4'($urandom) : (4'($urandom) | 4'($urandom));
      for (int i = 0; i < 4; i++) din[i] = 12'($urandom);
      req   = ($urandom_range(0, 2) == 0);
      idx   = 2'($urandom);
      tick();
    end

    reset = 1'b0; init = 1'b0; pause = 1'b0; req = 1'b0; empty = 4'hF;
    tick();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pop_arbiter.md
POP_ARBITER -- requirements
Module: pop_arbiter

Interface
REQ-001 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- init  input  1  one-cycle pulse; clears the packet counters and enters ACTIVE.
- emptyP0..emptyP3  input  1 each  empty flag of output FIFO P0..P3.
- dataOutputP0..dataOutputP3  input  12 each  FIFO read data, valid the cycle after a pop.
- pause  input  1  downstream almost-full; blocks new pops.
- req  input  1  counter read request.
- idx  input  2  counter index for req, 0..3.
- popOutP0..popOutP3  output  1 each  pop strobe to FIFO P0..P3.
- data_out  output  12  merged data word.
- valid_out  output  1  data_out valid this cycle.
- counterOut  output  5  counter value selected by idx.
- counterValid  output  1  counterOut valid.

Function
REQ-002 The FSM SHALL have states RESET, INIT, IDLE and ACTIVE, held in a 2-bit register.
REQ-003 Transitions SHALL be:
- RESET->INIT on the first cycle with reset low.
- INIT->IDLE after one cycle.
- IDLE->ACTIVE when init=1.
- ACTIVE->IDLE never happens except by reset.
REQ-004 In ACTIVE, when pause=0, at most one popOutPx SHALL assert per cycle.
- The selected port is the first non-empty port at or after the round-robin pointer rr.
REQ-005 rr SHALL advance to (granted port+1) mod 4 after each grant; it SHALL be unchanged when there is no grant.
REQ-006 No pop SHALL assert while pause=1, while the FSM is outside ACTIVE, or to a port whose empty flag is 1.
REQ-007 A pop issued in cycle N SHALL produce valid_out=1 in cycle N+1.
- In that cycle, data_out SHALL equal dataOutputPx of the granted port (registered output).
REQ-008 When no pop occurred in cycle N, valid_out SHALL be 0 in cycle N+1 and data_out SHALL hold its previous value.
REQ-009 Sustained throughput SHALL be one word per cycle when any FIFO is non-empty and pause=0.
REQ-010 A pause that asserts in cycle N SHALL still let a pop granted in cycle N-1 complete in cycle N.
REQ-011 Each port x SHALL have a 5-bit counter cnt[x], incremented by one on every valid_out from port x.
- The counter wraps 31->0.
REQ-012 req=1 in cycle N SHALL give counterValid=1 and counterOut=cnt[idx] in cycle N+1.
- The value sampled is the counter value at the edge ending cycle N.
- Otherwise counterValid=0 and counterOut holds its value.
REQ-013 If req coincides with an increment of the same counter, counterOut SHALL report the pre-increment value.
REQ-014 init=1 in IDLE or ACTIVE SHALL clear all counters and rr to 0.
- A pop already in flight still completes; its increment is dropped in the clearing cycle.

Reset
REQ-015 While reset=1, the following SHALL hold 0 from the next edge:
- all popOutPx, valid_out, data_out, counterValid, counterOut, cnt[0..3] and rr;
- the FSM SHALL be in RESET.
REQ-016 Reset asserted mid-operation SHALL discard any in-flight pop result (valid_out=0 the following cycle).

Structure
REQ-017 The FSM state encodings, NUM_PORTS=4, DATA_W=12 and CNT_W=5 SHALL live in the shared transaction-layer package.
REQ-018 A single sub-module, rr_arbiter (4-request round-robin grant with pointer), SHALL be instantiated; the counters and the FSM stay in pop_arbiter.

Verification
REQ-019 Directed bench scenarios SHALL cover:
- Reset: reset 2 cycles, then init -> all outputs 0; FSM reaches ACTIVE.
- Round robin: all FIFOs non-empty holding 15, 20, 25, 30 -> pops P0, P1, P2, P3, P0 in consecutive cycles; data_out 15, 20, 25, 30 with 1-cycle latency.
- Skip empty: only P2 non-empty (value 35) -> popOutP2 only; data_out=35, valid_out=1 the next cycle.
- Pause: pause=1 for 3 cycles -> zero pops; a pop granted the cycle before pause still gives valid_out.
- Counters: 33 words from P1, then req idx=1 -> counterValid=1, counterOut=1 (wrap).
- Reset mid-stream: reset during ACTIVE pops -> valid_out=0 on the next cycle and counters read 0 after init.
